// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-bus sequencer: ADC reset pulse, periodic CONVST, BUSY handshake,
// then an 8-word CS/RD readout published as one frame with a one-cycle valid strobe.
module ad7606_ctrl #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned RST_CYCLES    = 10,
    parameter int unsigned CONV_LOW      = 5,
    parameter int unsigned RD_LOW        = 4,
    parameter int unsigned RD_HIGH       = 2,
    parameter int unsigned BUSY_TIMEOUT  = 500,
    parameter logic [2:0]  OS_RATIO      = 3'b000
) (
    input  logic        clk,
    input  logic        ad_reset,
    input  logic [15:0] ad_data,
    input  logic        ad_busy,
    input  logic        ad_first_data,
    output logic [2:0]  ad_os,
    output logic        ad_adc_reset,
    output logic        ad_convst,
    output logic        ad_cs,
    output logic        ad_rd,
    output logic [15:0] ad_ch1,
    output logic [15:0] ad_ch2,
    output logic [15:0] ad_ch3,
    output logic [15:0] ad_ch4,
    output logic [15:0] ad_ch5,
    output logic [15:0] ad_ch6,
    output logic [15:0] ad_ch7,
    output logic [15:0] ad_ch8,
    output logic        ch_valid,
    output logic        ad_err
);

    localparam int unsigned RD_WORD = RD_LOW + RD_HIGH;
    localparam int unsigned M1      = (RST_CYCLES > CONV_LOW) ? RST_CYCLES : CONV_LOW;
    localparam int unsigned M2      = (BUSY_TIMEOUT > RD_WORD) ? BUSY_TIMEOUT : RD_WORD;
    localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int          CW      = $clog2(CNT_MAX + 1);
    localparam int          TW      = $clog2(SAMPLE_PERIOD);

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_CONV, S_BUSY_H, S_BUSY_L, S_READ, S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    word_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          tick;
    logic          pend_q, bad_q;
    logic          busy_meta_q, busy_s_q, fd_meta_q, fd_s_q;
    logic [15:0]   shadow_q [8];
    logic [15:0]   ch_q     [8];
    logic          adc_reset_q, convst_q, cs_q, rd_q, valid_q, err_q;

    always_comb begin
        tick    = (timer_q == TW'(SAMPLE_PERIOD - 1));
        timer_d = tick ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (ad_reset) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
            fd_meta_q   <= 1'b0;
            fd_s_q      <= 1'b0;
        end else begin
            busy_meta_q <= ad_busy;
            busy_s_q    <= busy_meta_q;
            fd_meta_q   <= ad_first_data;
            fd_s_q      <= fd_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ad_reset || state_q == S_RST) timer_q <= '0;
        else                              timer_q <= timer_d;
    end

    always_ff @(posedge clk) begin
        if (ad_reset) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            word_q      <= '0;
            pend_q      <= 1'b0;
            bad_q       <= 1'b0;
            adc_reset_q <= 1'b1;
            convst_q    <= 1'b1;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
                ch_q[i]     <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            // Ticks that land mid-frame collapse into a single pending request.
            if (tick && state_q != S_IDLE && state_q != S_RST) pend_q <= 1'b1;
            case (state_q)
                S_RST: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        adc_reset_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (tick || pend_q) begin
                        pend_q   <= 1'b0;
                        convst_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (cnt_q == CW'(CONV_LOW - 1)) begin
                        convst_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY_H;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BUSY_H: begin
                    if (busy_s_q) begin
                        cnt_q   <= '0;
                        state_q <= S_BUSY_L;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BUSY_L: begin
                    if (!busy_s_q) begin
                        cnt_q   <= '0;
                        word_q  <= '0;
                        bad_q   <= 1'b0;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        state_q <= S_READ;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_READ: begin
                    // cnt_q spans one word: RD_LOW cycles low, then RD_HIGH cycles high.
                    if (cnt_q == CW'(RD_LOW - 1)) begin
                        shadow_q[word_q] <= ad_data;
                        if (word_q == 3'd0 && !fd_s_q) bad_q <= 1'b1;
                        rd_q  <= 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                    end else if (cnt_q == CW'(RD_WORD - 1)) begin
                        cnt_q <= '0;
                        if (word_q == 3'd7) begin
                            cs_q    <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            word_q <= word_q + 1'b1;
                            rd_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bad_q) begin
                        err_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b1;
                        for (int unsigned i = 0; i < 8; i++) ch_q[i] <= shadow_q[i];
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_RST;
            endcase
        end
    end

    assign ad_os        = OS_RATIO;
    assign ad_adc_reset = adc_reset_q;
    assign ad_convst    = convst_q;
    assign ad_cs        = cs_q;
    assign ad_rd        = rd_q;
    assign ch_valid     = valid_q;
    assign ad_err       = err_q;
    assign ad_ch1       = ch_q[0];
    assign ad_ch2       = ch_q[1];
    assign ad_ch3       = ch_q[2];
    assign ad_ch4       = ch_q[3];
    assign ad_ch5       = ch_q[4];
    assign ad_ch6       = ch_q[5];
    assign ad_ch7       = ch_q[6];
    assign ad_ch8       = ch_q[7];

endmodule
